capp_word_array: RTL and testbench

- Word-memory and tag stage of the content-addressable parallel processor.
- Sits directly downstream of the comparand/mask stage and consumes its 2-per-bit mismatch lines.
- Stores NUM_WORDS words and evaluates every word against the mismatch lines in parallel.
- Updates a per-word tag register, resolves responders (some/none, first responder, count), sequences through responders, and performs masked multi-writes into all tagged words.

---
 rtl/capp_word_array_if.sv | 42 ++++
 rtl/capp_word_array.sv | 168 ++++++++++++++++
 tb/tb_capp_word_array.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/capp_word_array_if.sv
// Bundle between the controller and the CAPP word array:
// mismatch lines, command strobes, load port and resolver results.
interface capp_word_array_if #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 16,
    parameter int IDX_W      = 4
);
    logic [2*WORD_WIDTH-1:0] mismatch_lines;
    logic                    search_valid;
    logic [1:0]              tag_mode;
    logic                    tag_set_all;
    logic                    write_tagged;
    logic [WORD_WIDTH-1:0]   write_data;
    logic [WORD_WIDTH-1:0]   write_mask;
    logic                    step_next;
    logic                    load_en;
    logic [IDX_W-1:0]        load_addr;
    logic [WORD_WIDTH-1:0]   load_data;
    logic                    busy;
    logic                    done;
    logic                    some_responders;
    logic [IDX_W-1:0]        first_idx;
    logic [IDX_W:0]          responder_count;
    logic [WORD_WIDTH-1:0]   rd_data;
    logic [NUM_WORDS-1:0]    tags;

    modport master (
        output mismatch_lines, search_valid, tag_mode, tag_set_all,
        output write_tagged, write_data, write_mask, step_next,
        output load_en, load_addr, load_data,
        input  busy, done, some_responders, first_idx,
        input  responder_count, rd_data, tags
    );

    modport slave (
        input  mismatch_lines, search_valid, tag_mode, tag_set_all,
        input  write_tagged, write_data, write_mask, step_next,
        input  load_en, load_addr, load_data,
        output busy, done, some_responders, first_idx,
        output responder_count, rd_data, tags
    );
endinterface

// File: rtl/capp_word_array.sv
// CAPP word memory and tag stage: parallel match, tag update,
// responder resolution, stepping and masked multi-write.
module capp_word_array #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 16,
    parameter int IDX_W      = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    capp_word_array_if.slave  bus
);
    localparam int CW = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_RESOLVE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_WIDTH-1:0] r_words [NUM_WORDS];
    logic [NUM_WORDS-1:0]  r_tags;
    logic                  r_done;
    logic                  r_some;
    logic [IDX_W-1:0]      r_first;
    logic [CW-1:0]         r_count;
    logic [WORD_WIDTH-1:0] r_rd;

    logic [WORD_WIDTH-1:0] w_cmp_one;
    logic [WORD_WIDTH-1:0] w_cmp_zero;
    logic [NUM_WORDS-1:0]  w_match;
    logic [NUM_WORDS-1:0]  w_tags_nxt;
    logic                  w_accept;
    logic                  w_do_search;
    logic                  w_do_write;
    logic                  w_do_step;
    logic                  w_do_set;
    logic                  w_do_load;
    logic                  w_go;
    logic                  w_found;
    logic [IDX_W-1:0]      w_first;
    logic [CW-1:0]         w_count;
    logic [WORD_WIDTH-1:0] w_rd;

    always_comb begin
        w_cmp_one  = '0;
        w_cmp_zero = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            w_cmp_one[i]  = bus.mismatch_lines[2*i];
            w_cmp_zero[i] = bus.mismatch_lines[2*i+1];
        end
    end

    always_comb begin
        w_match = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            w_match[w] = ~|((w_cmp_one & ~r_words[w]) |
                            (w_cmp_zero & r_words[w]));
        end
    end

    // The done cycle still counts as busy so no command overlaps it.
    assign w_accept    = (r_state == S_IDLE) && !r_done;
    assign w_do_search = w_accept && bus.search_valid;
    assign w_do_write  = w_accept && !bus.search_valid && bus.write_tagged;
    assign w_do_step   = w_accept && !bus.search_valid && !bus.write_tagged
                         && bus.step_next;
    assign w_do_set    = w_accept && !bus.search_valid && !bus.write_tagged
                         && !bus.step_next && bus.tag_set_all;
    assign w_do_load   = w_accept && !bus.search_valid && !bus.write_tagged
                         && !bus.step_next && !bus.tag_set_all && bus.load_en;
    assign w_go        = w_do_search | w_do_write | w_do_step | w_do_set;

    always_comb begin
        w_found = 1'b0;
        w_first = '0;
        w_count = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_tags[k] && !w_found) begin
                w_found = 1'b1;
                w_first = IDX_W'(k);
            end
            w_count = w_count + CW'(r_tags[k]);
        end
    end

    assign w_rd = w_found ? r_words[w_first] : '0;

    always_comb begin
        w_tags_nxt = r_tags;
        unique case (1'b1)
            w_do_search: begin
                case (bus.tag_mode)
                    2'b01:   w_tags_nxt = r_tags & w_match;
                    2'b10:   w_tags_nxt = r_tags | w_match;
                    default: w_tags_nxt = w_match;
                endcase
            end
            w_do_step: begin
                if (w_found) w_tags_nxt[w_first] = 1'b0;
            end
            w_do_set: w_tags_nxt = '1;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_go) w_state_nxt = S_UPDATE;
            S_UPDATE:  w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_tags  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tags  <= w_tags_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int w = 0; w < NUM_WORDS; w++) r_words[w] <= '0;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (w_do_write && r_tags[w]) begin
                    r_words[w] <= (r_words[w] & ~bus.write_mask) |
                                  (bus.write_data & bus.write_mask);
                end else if (w_do_load && bus.load_addr == IDX_W'(w)) begin
                    r_words[w] <= bus.load_data;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_done  <= 1'b0;
            r_some  <= 1'b0;
            r_first <= '0;
            r_count <= '0;
            r_rd    <= '0;
        end else begin
            r_done <= (r_state == S_RESOLVE);
            if (r_state == S_RESOLVE) begin
                r_some  <= w_found;
                r_first <= w_first;
                r_count <= w_count;
                r_rd    <= w_rd;
            end
        end
    end

    assign bus.busy            = (r_state != S_IDLE) || r_done;
    assign bus.done            = r_done;
    assign bus.some_responders = r_some;
    assign bus.first_idx       = r_first;
    assign bus.responder_count = r_count;
    assign bus.rd_data         = r_rd;
    assign bus.tags            = r_tags;
endmodule

// File: tb/tb_capp_word_array.sv
// Directed bench for capp_word_array: search modes, stepping,
// multi-write, command priority, busy rejection and reset abort.
module tb_capp_word_array;
    logic CLK;
    logic RST_N;
    int   n_vec;
    int   n_err;

    capp_word_array_if #(.WORD_WIDTH(32), .NUM_WORDS(16), .IDX_W(4)) bus ();

    capp_word_array #(.WORD_WIDTH(32), .NUM_WORDS(16), .IDX_W(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lines(input logic [31:0] c,
                                          input logic [31:0] m);
        logic [63:0] l;
        l = '0;
        for (int i = 0; i < 32; i++) begin
            l[2*i]   = c[i] & m[i];
            l[2*i+1] = ~c[i] & m[i];
        end
        return l;
    endfunction

    task automatic clr();
        bus.search_valid = 1'b0;
        bus.tag_set_all  = 1'b0;
        bus.write_tagged = 1'b0;
        bus.step_next    = 1'b0;
        bus.load_en      = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_search(input logic [31:0] c, input logic [31:0] m,
                              input logic [1:0] mode);
        bus.mismatch_lines = lines(c, m);
        bus.tag_mode       = mode;
        bus.search_valid   = 1'b1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        clr();
        check("load_busy", 64'(bus.busy), 64'd0);
    endtask

    // Strobes are already driven; run to done and check the latency.
    task automatic fire(input string tag);
        int lat;
        tick();
        clr();
        check({tag, "_busy1"}, 64'(bus.busy), 64'd1);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_busy3"}, 64'(bus.busy), 64'd1);
        tick();
        check({tag, "_done_end"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic res(input string tag, input logic s, input logic [3:0] f,
                       input logic [4:0] n, input logic [31:0] rd,
                       input logic [15:0] t);
        check({tag, "_some"}, 64'(bus.some_responders), 64'(s));
        check({tag, "_first"}, 64'(bus.first_idx), 64'(f));
        check({tag, "_count"}, 64'(bus.responder_count), 64'(n));
        check({tag, "_rd"}, 64'(bus.rd_data), 64'(rd));
        check({tag, "_tags"}, 64'(bus.tags), 64'(t));
    endtask

    initial begin
        int ndone;
        n_vec = 0;
        n_err = 0;
        RST_N = 1'b0;
        clr();
        bus.mismatch_lines = '0;
        bus.tag_mode       = 2'b00;
        bus.write_data     = '0;
        bus.write_mask     = '0;
        bus.load_addr      = '0;
        bus.load_data      = '0;
        #22;
        res("reset", 1'b0, 4'd0, 5'd0, 32'd0, 16'h0000);
        check("reset_busy", 64'(bus.busy), 64'd0);
        RST_N = 1'b1;
        tick();

        // Abort a search mid-flight with reset.
        set_search(32'd0, 32'd0, 2'b00);
        tick();
        clr();
        check("abort_tags_pre", 64'(bus.tags), 64'hFFFF);
        #2 RST_N = 1'b0;
        #1;
        res("abort", 1'b0, 4'd0, 5'd0, 32'd0, 16'h0000);
        check("abort_busy", 64'(bus.busy), 64'd0);
        tick();
        RST_N = 1'b1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_tags", 64'(bus.tags), 64'h0);

        load(4'd0, 32'h0);
        load(4'd1, 32'hA5);
        load(4'd2, 32'h5A);
        load(4'd3, 32'hA5);
        set_search(32'hA5, 32'hFF, 2'b00);
        fire("srch_a5");
        res("srch_a5", 1'b1, 4'd1, 5'd2, 32'hA5, 16'h000A);

        bus.step_next = 1'b1;
        fire("step1");
        res("step1", 1'b1, 4'd3, 5'd1, 32'hA5, 16'h0008);
        bus.step_next = 1'b1;
        fire("step2");
        res("step2", 1'b0, 4'd0, 5'd0, 32'h0, 16'h0000);
        bus.step_next = 1'b1;
        fire("step3");
        res("step3", 1'b0, 4'd0, 5'd0, 32'h0, 16'h0000);

        bus.tag_set_all = 1'b1;
        fire("setall");
        res("setall", 1'b1, 4'd0, 5'd16, 32'h0, 16'hFFFF);
        set_search(32'h0, 32'h0, 2'b00);
        fire("srch_m0");
        res("srch_m0", 1'b1, 4'd0, 5'd16, 32'h0, 16'hFFFF);

        bus.write_tagged = 1'b1;
        bus.write_data   = 32'hFFFF0000;
        bus.write_mask   = 32'hFFFF0000;
        fire("mwrite");
        res("mwrite", 1'b1, 4'd0, 5'd16, 32'hFFFF0000, 16'hFFFF);
        bus.step_next = 1'b1;
        fire("mw_s1");
        res("mw_s1", 1'b1, 4'd1, 5'd15, 32'hFFFF00A5, 16'hFFFE);
        bus.step_next = 1'b1;
        fire("mw_s2");
        res("mw_s2", 1'b1, 4'd2, 5'd14, 32'hFFFF005A, 16'hFFFC);
        bus.step_next = 1'b1;
        fire("mw_s3");
        res("mw_s3", 1'b1, 4'd3, 5'd13, 32'hFFFF00A5, 16'hFFF8);
        bus.step_next = 1'b1;
        fire("mw_s4");
        res("mw_s4", 1'b1, 4'd4, 5'd12, 32'hFFFF0000, 16'hFFF0);

        // Load does not refresh the resolver outputs.
        load(4'd4, 32'hFFFF00A0);
        res("load_hold", 1'b1, 4'd4, 5'd12, 32'hFFFF0000, 16'hFFF0);

        set_search(32'h0, 32'hF, 2'b00);
        fire("nib0");
        res("nib0", 1'b1, 4'd0, 5'd13, 32'hFFFF0000, 16'hFFF1);
        set_search(32'hA0, 32'hF0, 2'b01);
        fire("and");
        res("and", 1'b1, 4'd4, 5'd1, 32'hFFFF00A0, 16'h0010);
        set_search(32'h5A, 32'hFF, 2'b10);
        fire("or");
        res("or", 1'b1, 4'd2, 5'd2, 32'hFFFF005A, 16'h0014);
        set_search(32'hA5, 32'hFF, 2'b11);
        fire("mode11");
        res("mode11", 1'b1, 4'd1, 5'd2, 32'hFFFF00A5, 16'h000A);

        // Search wins over a coincident write_tagged.
        set_search(32'h5A, 32'hFF, 2'b00);
        bus.write_tagged = 1'b1;
        bus.write_data   = 32'h0;
        bus.write_mask   = 32'hFFFFFFFF;
        fire("prio");
        res("prio", 1'b1, 4'd2, 5'd1, 32'hFFFF005A, 16'h0004);

        set_search(32'hA5, 32'hFF, 2'b00);
        tick();
        ndone = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.done === 1'b1) ndone++;
            clr();
            if (c == 1) set_search(32'h5A, 32'hFF, 2'b00);
            if (c == 3) bus.step_next = 1'b1;
            tick();
        end
        clr();
        check("busy_one_done", 64'(ndone), 64'd1);
        res("busy_ign", 1'b1, 4'd1, 5'd2, 32'hFFFF00A5, 16'h000A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
